// File: rtl/iconn_shuffle_if.sv
`default_nettype none
// ============================================================================
// Module   : iconn_shuffle_if
// Brief    : Vector handshake bus (in/out streams, status) of the shuffle stage.
// Revision : 1.0
// ============================================================================
interface iconn_shuffle_if #(
  parameter int NODE_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH      = 64,
  parameter int CNT_WIDTH       = 16
);
  localparam int c_lanes = 1 << NODE_ADDR_WIDTH;

  logic                                      in_valid;
  logic                                      in_ready;
  logic [1:0]                                in_mode;
  logic [c_lanes/2-1:0]                      in_xchg;
  logic [c_lanes-1:0][NODE_ADDR_WIDTH-1:0]   ain;
  logic [c_lanes-1:0][DATA_WIDTH-1:0]        din;
  logic [c_lanes-1:0]                        din_valid;
  logic                                      out_valid;
  logic                                      out_ready;
  logic [c_lanes-1:0][NODE_ADDR_WIDTH-1:0]   aout;
  logic [c_lanes-1:0][DATA_WIDTH-1:0]        dout;
  logic [c_lanes-1:0]                        dout_valid;
  logic [CNT_WIDTH-1:0]                      xfer_cnt;
  logic                                      err_mode;
  logic                                      cnt_clr;

  modport master (
    output in_valid, in_mode, in_xchg, ain, din, din_valid, out_ready, cnt_clr,
    input  in_ready, out_valid, aout, dout, dout_valid, xfer_cnt, err_mode
  );

  modport slave (
    input  in_valid, in_mode, in_xchg, ain, din, din_valid, out_ready, cnt_clr,
    output in_ready, out_valid, aout, dout, dout_valid, xfer_cnt, err_mode
  );
endinterface
`default_nettype wire

// File: rtl/iconn_shuffle_stage.sv
`default_nettype none
// ============================================================================
// Module   : iconn_shuffle_stage
// Brief    : Perfect-shuffle / unshuffle / bypass lane permutation with pair
//            exchange, output register plus skid buffer, transfer counter.
// Revision : 1.0
// ============================================================================
module iconn_shuffle_stage #(
  parameter int NODE_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH      = 64,
  parameter int CNT_WIDTH       = 16,
  parameter int ZERO_INVALID    = 0
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  iconn_shuffle_if.slave   bus
);
  localparam int c_lanes = 1 << NODE_ADDR_WIDTH;
  localparam int c_pairs = c_lanes / 2;
  localparam logic [1:0]           c_mode_shuf = 2'd0;
  localparam logic [1:0]           c_mode_unsh = 2'd1;
  localparam logic [1:0]           c_mode_rsvd = 2'd3;
  localparam logic [CNT_WIDTH-1:0] c_cnt_max   = '1;

  typedef logic [c_lanes-1:0][NODE_ADDR_WIDTH-1:0] addr_vec_t;
  typedef logic [c_lanes-1:0][DATA_WIDTH-1:0]      data_vec_t;
  typedef logic [c_lanes-1:0]                      lane_vec_t;

  addr_vec_t w_perm_a, w_sw_a, w_new_a;
  data_vec_t w_perm_d, w_sw_d, w_new_d;
  lane_vec_t w_perm_v, w_sw_v;

  // Each lane gathers from its source, then the pair exchange swaps neighbours.
  for (genvar i = 0; i < c_lanes; i++) begin : g_lane
    localparam int c_shuf_src = (i % 2 == 0) ? (i / 2) : (c_pairs + (i - 1) / 2);
    localparam int c_unsh_src = ((i << 1) | (i >> (NODE_ADDR_WIDTH - 1))) & (c_lanes - 1);
    localparam int c_mate     = i ^ 1;

    assign w_perm_a[i] = (bus.in_mode == c_mode_shuf) ? bus.ain[c_shuf_src] :
                         (bus.in_mode == c_mode_unsh) ? bus.ain[c_unsh_src] : bus.ain[i];
    assign w_perm_d[i] = (bus.in_mode == c_mode_shuf) ? bus.din[c_shuf_src] :
                         (bus.in_mode == c_mode_unsh) ? bus.din[c_unsh_src] : bus.din[i];
    assign w_perm_v[i] = (bus.in_mode == c_mode_shuf) ? bus.din_valid[c_shuf_src] :
                         (bus.in_mode == c_mode_unsh) ? bus.din_valid[c_unsh_src] : bus.din_valid[i];

    assign w_sw_a[i] = bus.in_xchg[i / 2] ? w_perm_a[c_mate] : w_perm_a[i];
    assign w_sw_d[i] = bus.in_xchg[i / 2] ? w_perm_d[c_mate] : w_perm_d[i];
    assign w_sw_v[i] = bus.in_xchg[i / 2] ? w_perm_v[c_mate] : w_perm_v[i];

    assign w_new_a[i] = (ZERO_INVALID != 0 && !w_sw_v[i]) ? '0 : w_sw_a[i];
    assign w_new_d[i] = (ZERO_INVALID != 0 && !w_sw_v[i]) ? '0 : w_sw_d[i];
  end

  addr_vec_t            r_out_a,  r_skid_a;
  data_vec_t            r_out_d,  r_skid_d;
  lane_vec_t            r_out_v,  r_skid_v;
  logic                 r_out_valid, r_skid_valid, r_in_ready;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_err;

  logic w_in_fire, w_out_fire, w_out_free;
  assign w_in_fire  = bus.in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & bus.out_ready;
  assign w_out_free = ~r_out_valid | bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_a      <= '0;
      r_out_d      <= '0;
      r_out_v      <= '0;
      r_out_valid  <= 1'b0;
      r_skid_a     <= '0;
      r_skid_d     <= '0;
      r_skid_v     <= '0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (w_out_free) begin
      // Skid content always wins the output slot; no input can fire while it is full.
      if (r_skid_valid) begin
        r_out_a      <= r_skid_a;
        r_out_d      <= r_skid_d;
        r_out_v      <= r_skid_v;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
        r_in_ready   <= 1'b1;
      end else if (w_in_fire) begin
        r_out_a      <= w_new_a;
        r_out_d      <= w_new_d;
        r_out_v      <= w_sw_v;
        r_out_valid  <= 1'b1;
      end else begin
        r_out_valid  <= 1'b0;
      end
    end else if (w_in_fire) begin
      r_skid_a     <= w_new_a;
      r_skid_d     <= w_new_d;
      r_skid_v     <= w_sw_v;
      r_skid_valid <= 1'b1;
      r_in_ready   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (bus.cnt_clr) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_out_fire && r_cnt != c_cnt_max) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_in_fire && bus.in_mode == c_mode_rsvd) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.aout       = r_out_a;
  assign bus.dout       = r_out_d;
  assign bus.dout_valid = r_out_v;
  assign bus.xfer_cnt   = r_cnt;
  assign bus.err_mode   = r_err;
endmodule
`default_nettype wire

// File: tb/tb_iconn_shuffle_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_iconn_shuffle_stage
// Brief    : Self-checking bench with a queue-based reference of the stage.
// Revision : 1.0
// ============================================================================
module tb_iconn_shuffle_stage;
  localparam int AW = 3;
  localparam int DW = 64;
  localparam int CW = 4;
  localparam int P  = 1 << AW;

  typedef struct {
    logic [P-1:0][AW-1:0] a;
    logic [P-1:0][DW-1:0] d;
    logic [P-1:0]         v;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  iconn_shuffle_if #(.NODE_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  iconn_shuffle_stage #(
    .NODE_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .ZERO_INVALID(1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  vec_t q[$];
  int   m_cnt;
  bit   m_err;
  int   m_pushes;
  int   n_checks;
  int   n_pass;

  // Scatter form: input lane j lands at its destination lane.
  function automatic vec_t model_perm(input logic [1:0] mode, input logic [P/2-1:0] xchg,
                                      input vec_t x);
    vec_t y;
    int   dst;
    y.a = '0; y.d = '0; y.v = '0;
    for (int j = 0; j < P; j++) begin
      if (mode == 2'd0)      dst = (j < P/2) ? 2*j : 2*(j - P/2) + 1;
      else if (mode == 2'd1) dst = (j >> 1) | ((j & 1) << (AW - 1));
      else                   dst = j;
      if (xchg[dst/2]) dst = dst ^ 1;
      y.v[dst] = x.v[j];
      y.a[dst] = x.v[j] ? x.a[j] : '0;
      y.d[dst] = x.v[j] ? x.d[j] : '0;
    end
    return y;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic compare();
    chk("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
    chk("in_ready",  64'(bus.in_ready),  64'(q.size() < 2));
    chk("xfer_cnt",  64'(bus.xfer_cnt),  64'(m_cnt));
    chk("err_mode",  64'(bus.err_mode),  64'(m_err));
    if (q.size() > 0) begin
      chk("dout_valid", 64'(bus.dout_valid), 64'(q[0].v));
      for (int i = 0; i < P; i++) begin
        chk("aout_lane", 64'(bus.aout[i]), 64'(q[0].a[i]));
        chk("dout_lane", bus.dout[i], q[0].d[i]);
      end
    end
  endtask

  // Model update on the edge using the bench's own view of ready/valid.
  task automatic step();
    bit   in_f, out_f;
    vec_t x;
    @(posedge clk);
    if (!rst_n) begin
      q.delete(); m_cnt = 0; m_err = 1'b0;
    end else begin
      in_f  = bus.in_valid && (q.size() < 2);
      out_f = (q.size() > 0) && bus.out_ready;
      x.a = bus.ain; x.d = bus.din; x.v = bus.din_valid;
      if (out_f) void'(q.pop_front());
      if (in_f) begin
        q.push_back(model_perm(bus.in_mode, bus.in_xchg, x));
        m_pushes++;
      end
      if (bus.cnt_clr) begin
        m_cnt = 0; m_err = 1'b0;
      end else begin
        if (out_f && m_cnt < (1 << CW) - 1) m_cnt++;
        if (in_f && bus.in_mode == 2'd3) m_err = 1'b1;
      end
    end
    @(negedge clk);
    compare();
  endtask

  task automatic set_vec(input logic [1:0] mode, input logic [P/2-1:0] xchg, input int base);
    bus.in_mode = mode;
    bus.in_xchg = xchg;
    for (int j = 0; j < P; j++) begin
      bus.ain[j] = AW'(j);
      bus.din[j] = 64'(base + j);
    end
    bus.din_valid = '1;
  endtask

  task automatic lit(input string name, input int e[P]);
    chk({name, "_valid"}, 64'(bus.out_valid), 64'd1);
    for (int i = 0; i < P; i++) begin
      chk({name, "_dout"}, bus.dout[i], 64'(e[i]));
      chk({name, "_aout"}, 64'(bus.aout[i]), 64'(e[i] & (P - 1)));
    end
  endtask

  int e_shuf[P]  = '{0, 4, 1, 5, 2, 6, 3, 7};
  int e_unsh[P]  = '{0, 2, 4, 6, 1, 3, 5, 7};
  int e_xchg[P]  = '{4, 0, 1, 5, 2, 6, 3, 7};
  int e_ident[P] = '{0, 1, 2, 3, 4, 5, 6, 7};

  initial begin
    int p0;
    n_checks = 0; n_pass = 0; m_cnt = 0; m_err = 1'b0; m_pushes = 0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.cnt_clr = 1'b0;
    set_vec(2'd0, '0, 0);

    repeat (2) step();
    chk("rst_dout",       bus.dout[3], 64'd0);
    chk("rst_dout_valid", 64'(bus.dout_valid), 64'd0);
    rst_n = 1'b1;
    step();

    set_vec(2'd0, '0, 0); bus.in_valid = 1'b1; step(); bus.in_valid = 1'b0;
    lit("shuffle", e_shuf);
    set_vec(2'd1, '0, 0); bus.in_valid = 1'b1; step(); bus.in_valid = 1'b0;
    lit("unshuffle", e_unsh);
    bus.in_mode = 2'd0;
    for (int j = 0; j < P; j++) begin
      bus.ain[j] = AW'(e_unsh[j]);
      bus.din[j] = 64'(e_unsh[j]);
    end
    bus.in_valid = 1'b1; step(); bus.in_valid = 1'b0;
    lit("roundtrip", e_ident);
    set_vec(2'd0, 4'b0001, 0); bus.in_valid = 1'b1; step(); bus.in_valid = 1'b0;
    lit("xchg", e_xchg);
    step();
    bus.cnt_clr = 1'b1; step(); bus.cnt_clr = 1'b0;

    // Stall with three vectors offered back-to-back
    bus.out_ready = 1'b0;
    p0 = m_pushes;
    set_vec(2'd2, '0, 100); bus.in_valid = 1'b1; step();
    set_vec(2'd2, '0, 200); step();
    set_vec(2'd2, '0, 300); step();
    chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
    chk("stall_head",     bus.dout[0], 64'd100);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10 && m_pushes < p0 + 3; k++) step();
    chk("stall_c_accepted", 64'(m_pushes), 64'(p0 + 3));
    bus.in_valid = 1'b0;
    repeat (3) step();
    chk("stall_xfer3", 64'(bus.xfer_cnt), 64'd3);

    // Counter saturation, clear priority, reserved mode
    bus.cnt_clr = 1'b1; step(); bus.cnt_clr = 1'b0;
    set_vec(2'd2, '0, 0); bus.in_valid = 1'b1;
    repeat (20) step();
    bus.in_valid = 1'b0; step();
    chk("sat15", 64'(bus.xfer_cnt), 64'd15);
    bus.in_valid = 1'b1; step();
    bus.cnt_clr = 1'b1; step(); bus.cnt_clr = 1'b0;
    chk("clr_prio", 64'(bus.xfer_cnt), 64'd0);
    set_vec(2'd3, '0, 0); step(); bus.in_valid = 1'b0;
    chk("err_set", 64'(bus.err_mode), 64'd1);
    lit("reserved", e_ident);

    for (int c = 0; c < 1500; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.in_mode   = 2'($urandom_range(0, 3));
      bus.in_xchg   = (P/2)'($urandom);
      bus.din_valid = P'($urandom);
      bus.cnt_clr   = ($urandom_range(0, 49) == 0);
      for (int j = 0; j < P; j++) begin
        bus.ain[j] = AW'($urandom_range(0, P - 1));
        bus.din[j] = {$urandom, $urandom};
      end
      step();
    end

    // Reset with both registers full
    bus.cnt_clr = 1'b0; bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    set_vec(2'd2, '0, 500);
    repeat (3) step();
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid",  64'(bus.out_valid), 64'd0);
    chk("arst_in_ready",   64'(bus.in_ready), 64'd1);
    chk("arst_xfer_cnt",   64'(bus.xfer_cnt), 64'd0);
    chk("arst_dout_valid", 64'(bus.dout_valid), 64'd0);
    chk("arst_dout",       bus.dout[0], 64'd0);
    q.delete(); m_cnt = 0; m_err = 1'b0;
    bus.in_valid = 1'b0;
    step();
    rst_n = 1'b1; bus.out_ready = 1'b1;
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
